// File: rtl/riscv_fetch_pkg.sv
// Shared fetch-path types: architectural widths, the buffered fetch entry
// and the sequential-PC helper used by both the request and response sides.
package riscv_fetch_pkg;

  localparam int unsigned XLEN       = 32;
  localparam int unsigned INST_BYTES = 4;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] inst;
  } fetch_entry_t;

  function automatic logic [XLEN-1:0] next_pc(input logic [XLEN-1:0] pc);
    return pc + XLEN'(INST_BYTES);
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Circular storage for fetched {pc, inst} entries. Flush empties it and wins
// over a push or pop in the same cycle; the head is read combinationally.
module fetch_fifo
  import riscv_fetch_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  localparam int unsigned PW   = $clog2(DEPTH),
  localparam int unsigned CW   = PW + 1
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          flush_i,
  input  logic          push_i,
  input  fetch_entry_t  entry_i,
  input  logic          pop_i,
  output fetch_entry_t  head_o,
  output logic [CW-1:0] count_o
);

  fetch_entry_t  mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          do_push_s;
  logic          do_pop_s;

  // Qualify push/pop against flush and the occupancy limits.
  always_comb begin
    do_push_s = push_i && !flush_i && (count_q != CW'(DEPTH));
    do_pop_s  = pop_i && !flush_i && (count_q != {CW{1'b0}});
  end

  // Pointer and occupancy next-state; pointers wrap naturally at PW bits.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = {PW{1'b0}};
      rd_ptr_d = {PW{1'b0}};
      count_d  = {CW{1'b0}};
    end else begin
      if (do_push_s) begin
        wr_ptr_d = wr_ptr_q + PW'(1);
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (do_pop_s) begin
        rd_ptr_d = rd_ptr_q + PW'(1);
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      case ({do_push_s, do_pop_s})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Control state registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= {PW{1'b0}};
      rd_ptr_q <= {PW{1'b0}};
      count_q  <= {CW{1'b0}};
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage; contents are don't-care until written, so no reset.
  always_ff @(posedge clk_i) begin
    if (do_push_s) begin
      mem_q[wr_ptr_q] <= entry_i;
    end
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/instruction_prefetch_buffer.sv
// Sequential instruction prefetcher: issues in-order fetches while buffer space
// is guaranteed, tags responses with their PC and drains stale ones after redirect.
module instruction_prefetch_buffer
  import riscv_fetch_pkg::*;
#(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        deq_valid,
  input  logic        deq_ready,
  output logic [31:0] deq_inst,
  output logic [31:0] deq_pc,
  output logic        err_unexp
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;

  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic [XLEN-1:0] resp_pc_q, resp_pc_d;
  logic [CW-1:0]   live_q, live_d;
  logic [CW-1:0]   drop_q, drop_d;
  logic            err_q, err_d;

  logic [CW-1:0]   count_s;
  logic [CW:0]     occ_s;
  logic            accept_s;
  logic            drop_resp_s;
  logic            live_resp_s;
  logic            unexp_s;
  logic            push_s;
  logic            pop_s;
  fetch_entry_t    entry_s;
  fetch_entry_t    head_s;

  // Credit check counts only registered state so a pop never frees space early.
  always_comb begin
    occ_s     = {1'b0, count_s} + {1'b0, live_q};
    imem_req  = reset && !redirect && (occ_s < (CW+1)'(DEPTH));
    imem_addr = fetch_pc_q;
  end

  // Classify this cycle's handshakes; stale responses are consumed before live ones.
  always_comb begin
    accept_s    = imem_req && imem_ready;
    drop_resp_s = imem_rvalid && (drop_q != {CW{1'b0}});
    live_resp_s = imem_rvalid && (drop_q == {CW{1'b0}}) && (live_q != {CW{1'b0}});
    unexp_s     = imem_rvalid && (drop_q == {CW{1'b0}}) && (live_q == {CW{1'b0}});
    push_s      = live_resp_s && !redirect;
    pop_s       = deq_valid && deq_ready && !redirect;
    entry_s     = '{pc: resp_pc_q, inst: imem_rdata};
  end

  // Fetch/response PCs and request accounting.
  always_comb begin
    fetch_pc_d = fetch_pc_q;
    resp_pc_d  = resp_pc_q;
    live_d     = live_q;
    drop_d     = drop_q;
    err_d      = err_q | unexp_s;
    if (redirect) begin
      // Everything still in flight becomes stale, except a live response landing now.
      fetch_pc_d = redirect_pc;
      resp_pc_d  = redirect_pc;
      live_d     = {CW{1'b0}};
      drop_d     = drop_q + live_q - CW'(drop_resp_s) - CW'(live_resp_s);
    end else begin
      if (accept_s) begin
        fetch_pc_d = next_pc(fetch_pc_q);
      end else begin
        fetch_pc_d = fetch_pc_q;
      end
      if (push_s) begin
        resp_pc_d = next_pc(resp_pc_q);
      end else begin
        resp_pc_d = resp_pc_q;
      end
      case ({accept_s, live_resp_s})
        2'b10:   live_d = live_q + CW'(1);
        2'b01:   live_d = live_q - CW'(1);
        default: live_d = live_q;
      endcase
      drop_d = drop_q - CW'(drop_resp_s);
    end
  end

  // Request-side state registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fetch_pc_q <= RESET_PC;
      resp_pc_q  <= RESET_PC;
      live_q     <= {CW{1'b0}};
      drop_q     <= {CW{1'b0}};
      err_q      <= 1'b0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      resp_pc_q  <= resp_pc_d;
      live_q     <= live_d;
      drop_q     <= drop_d;
      err_q      <= err_d;
    end
  end

  fetch_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i   (clk),
    .rst_ni  (reset),
    .flush_i (redirect),
    .push_i  (push_s),
    .entry_i (entry_s),
    .pop_i   (pop_s),
    .head_o  (head_s),
    .count_o (count_s)
  );

  assign deq_valid = (count_s != {CW{1'b0}});
  assign deq_inst  = head_s.inst;
  assign deq_pc    = head_s.pc;
  assign err_unexp = err_q;

endmodule

// File: tb/tb_instruction_prefetch_buffer.sv
// Directed + random bench: an in-order memory model and a consumer model
// predict request gating, fetch addresses and the delivered PC/instruction stream.
module tb_instruction_prefetch_buffer;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset, redirect, imem_req, imem_ready, imem_rvalid;
  logic        deq_valid, deq_ready, err_unexp;
  logic [31:0] redirect_pc, imem_addr, imem_rdata, deq_inst, deq_pc;

  always #5 clk = ~clk;

  instruction_prefetch_buffer #(.DEPTH(DEPTH), .RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .reset(reset), .redirect(redirect), .redirect_pc(redirect_pc),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .deq_valid(deq_valid), .deq_ready(deq_ready), .deq_inst(deq_inst),
    .deq_pc(deq_pc), .err_unexp(err_unexp)
  );

  int total = 0;
  int bad   = 0;

  // Model: requests in flight (address + redirect epoch), buffered entry count, next PCs.
  logic [31:0] pend_addr[$];
  int          pend_ep[$];
  int          epoch = 0;
  int          mcount = 0;
  logic [31:0] exp_pc, exp_fetch;
  logic        exp_err;

  int          p_ready = 0, p_rsp = 0, p_deq = 0;
  logic        rst_val = 1'b0;
  bit          redir_req = 1'b0, spur_req = 1'b0;
  logic [31:0] redir_target = 32'h0;
  logic        obs_req, obs_acc, obs_dv, obs_err;
  logic [31:0] obs_addr, obs_deq_pc;

  function automatic logic [31:0] inst_of(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
  endfunction

  function automatic bit pick(input int p);
    if (p == 0) return 1'b0;
    if (p == 1) return 1'b1;
    return ($urandom_range(1, 0) == 1);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    pend_addr.delete();
    pend_ep.delete();
    epoch++;
    mcount    = 0;
    exp_pc    = 32'h0;
    exp_fetch = 32'h0;
    exp_err   = 1'b0;
  endtask

  task automatic cycle();
    bit   rsp_go, spur, acc, pop, exp_req;
    int   live_pend;
    @(negedge clk);
    reset       = rst_val;
    redirect    = rst_val && redir_req;
    redir_req   = 1'b0;
    redirect_pc = redir_target;
    imem_ready  = pick(p_ready);
    deq_ready   = pick(p_deq);
    rsp_go      = rst_val && (pend_addr.size() > 0) && pick(p_rsp);
    spur        = rst_val && spur_req && (pend_addr.size() == 0);
    spur_req    = 1'b0;
    imem_rvalid = rsp_go || spur;
    if (rsp_go) imem_rdata = inst_of(pend_addr[0]);
    else        imem_rdata = $urandom();
    if (!rst_val) model_reset();
    #1;
    live_pend = 0;
    foreach (pend_ep[i]) if (pend_ep[i] == epoch) live_pend++;
    exp_req = rst_val && !redirect && ((mcount + live_pend) < DEPTH);
    chk("imem_req", imem_req, exp_req);
    if (exp_req) chk("imem_addr", imem_addr, exp_fetch);
    chk("deq_valid", deq_valid, (mcount != 0));
    chk("err_unexp", err_unexp, exp_err);
    pop = (mcount != 0) && deq_ready && !redirect;
    if (pop) begin
      chk("deq_pc", deq_pc, exp_pc);
      chk("deq_inst", deq_inst, inst_of(exp_pc));
    end
    obs_req = imem_req; obs_acc = imem_req && imem_ready; obs_dv = deq_valid;
    obs_err = err_unexp; obs_addr = imem_addr; obs_deq_pc = deq_pc;
    acc = exp_req && imem_ready;
    @(posedge clk);
    if (rsp_go) begin
      if (pend_ep[0] == epoch && !redirect) mcount++;
      void'(pend_addr.pop_front());
      void'(pend_ep.pop_front());
    end
    if (spur) exp_err = 1'b1;
    if (pop) begin
      mcount--;
      exp_pc += 32'd4;
    end
    if (acc) begin
      pend_addr.push_back(exp_fetch);
      pend_ep.push_back(epoch);
      exp_fetch += 32'd4;
    end
    if (redirect) begin
      epoch++;
      mcount    = 0;
      exp_fetch = redirect_pc;
      exp_pc    = redirect_pc;
    end
  endtask

  initial begin
    int          acc_total;
    bit          found;
    logic [31:0] held, rnd;
    reset = 1'b0; redirect = 1'b0; redirect_pc = 32'h0; imem_ready = 1'b0;
    imem_rvalid = 1'b0; imem_rdata = 32'h0; deq_ready = 1'b0;
    model_reset();

    // Held in reset: no requests, nothing valid, no error.
    repeat (3) cycle();
    chk("rst_req", obs_req, 1'b0);

    // Streaming: addresses 0,4,8.. and one delivered instruction per cycle after fill.
    rst_val = 1'b1; p_ready = 1; p_rsp = 1; p_deq = 1;
    cycle();
    chk("first_addr", obs_addr, 32'h0);
    chk("first_acc", obs_acc, 1'b1);
    for (int k = 1; k < 12; k++) begin
      cycle();
      if (k >= 2) begin
        chk("stream_dv", obs_dv, 1'b1);
        chk("stream_pc", obs_deq_pc, 32'(4 * (k - 2)));
      end
    end

    // Consumer stalled: exactly DEPTH requests, then one more per single pop.
    p_deq = 0; redir_req = 1'b1; redir_target = 32'h0000_0100;
    cycle();
    acc_total = 0;
    repeat (12) begin
      cycle();
      acc_total += int'(obs_acc);
    end
    chk("fill_acc", acc_total, DEPTH);
    chk("full_req", obs_req, 1'b0);
    p_deq = 1;
    cycle();
    p_deq = 0;
    acc_total = 0;
    repeat (6) begin
      cycle();
      acc_total += int'(obs_acc);
    end
    chk("one_more_acc", acc_total, 1);

    // Drain, then two requests in flight (0x10, 0x14) discarded by redirect to 0x200.
    p_deq = 1; p_ready = 0;
    repeat (8) cycle();
    p_rsp = 0; p_ready = 1; redir_req = 1'b1; redir_target = 32'h0000_0010;
    cycle();
    cycle();
    chk("req_0x10", obs_addr, 32'h0000_0010);
    cycle();
    chk("req_0x14", obs_addr, 32'h0000_0014);
    p_ready = 0; redir_req = 1'b1; redir_target = 32'h0000_0200;
    cycle();
    p_rsp = 1; p_ready = 1; found = 1'b0;
    for (int k = 0; k < 10 && !found; k++) begin
      cycle();
      if (obs_dv) begin
        found = 1'b1;
        chk("redir_first_pc", obs_deq_pc, 32'h0000_0200);
      end
    end
    chk("redir_seen", found, 1'b1);

    // Memory stalls with a request pending: address holds, buffer unchanged.
    p_ready = 0; p_deq = 1;
    repeat (8) cycle();
    p_deq = 0; held = exp_fetch;
    repeat (5) begin
      cycle();
      chk("stall_req", obs_req, 1'b1);
      chk("stall_addr", obs_addr, held);
      chk("stall_dv", obs_dv, 1'b0);
    end

    // Redirect in a cycle with both a push and a pop in progress.
    p_ready = 1; p_rsp = 1; p_deq = 1;
    repeat (6) cycle();
    redir_req = 1'b1; redir_target = 32'h0000_0400;
    cycle();
    cycle();
    chk("rd_dv_clear", obs_dv, 1'b0);
    found = 1'b0;
    for (int k = 0; k < 10 && !found; k++) begin
      cycle();
      if (obs_dv) begin
        found = 1'b1;
        chk("rd_first_pc", obs_deq_pc, 32'h0000_0400);
      end
    end
    chk("rd_seen", found, 1'b1);

    // Randomised traffic, starting near the top of the address space to exercise wrap.
    redir_req = 1'b1; redir_target = 32'hFFFF_FFF0;
    p_ready = 2; p_rsp = 2; p_deq = 2;
    for (int k = 0; k < 600; k++) begin
      if ($urandom_range(24, 0) == 0 && pend_addr.size() <= DEPTH) begin
        rnd = $urandom();
        redir_req = 1'b1;
        redir_target = rnd & 32'hFFFF_FFFC;
      end
      cycle();
    end

    // Reset mid-transfer, then a response with nothing outstanding.
    p_ready = 1; p_rsp = 1; p_deq = 0;
    repeat (3) cycle();
    rst_val = 1'b0;
    repeat (2) cycle();
    rst_val = 1'b1; p_ready = 0; spur_req = 1'b1;
    cycle();
    repeat (4) cycle();
    chk("err_sticky", obs_err, 1'b1);
    chk("err_dv", obs_dv, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/instruction_prefetch_buffer.md
INSTRUCTION_PREFETCH_BUFFER -- requirements
Module: instruction_prefetch_buffer

Interface
REQ-001 Parameter DEPTH, default 4, is the FIFO entry count; it SHALL be a power of 2 and at least 2.
REQ-002 Parameter RESET_PC, default 32'h0000_0000, is the first fetch address after reset.
REQ-003 One clock, clk; reset is asynchronous and active-low, port reset.
REQ-004 Ports SHALL be:
- clk  in  1  rising-edge clock
- reset  in  1  async active-low reset
- redirect  in  1  restart fetch at redirect_pc (branch/jump resolved in ID)
- redirect_pc  in  32  new fetch address
- imem_req  out  1  fetch request valid
- imem_addr  out  32  fetch address
- imem_ready  in  1  memory accepts request when imem_req&&imem_ready
- imem_rvalid  in  1  in-order response valid
- imem_rdata  in  32  response instruction word
- deq_valid  out  1  head entry available to IF stage
- deq_ready  in  1  IF stage consumes head (driven by PC_Write)
- deq_inst  out  32  head instruction
- deq_pc  out  32  head instruction address
- err_unexp  out  1  sticky: response arrived with nothing outstanding

Function
REQ-005 fetch_pc SHALL drive imem_addr; on each accepted request it SHALL advance by 4, wrapping modulo 2^32.
REQ-006 imem_req SHALL be asserted iff redirect==0 and (count + live_outstanding) < DEPTH, using registered values only (no same-cycle credit from a dequeue).
REQ-007 live_outstanding SHALL increment on accepted request, decrement on a non-dropped response, and both in one cycle SHALL leave it unchanged.
REQ-008 resp_pc SHALL tag each non-dropped response; it advances by 4 per written entry.
REQ-009 A non-dropped imem_rvalid SHALL write {resp_pc, imem_rdata} at the tail on the next rising edge; deq_valid SHALL rise no earlier than the cycle after the response (no bypass).
REQ-010 deq_valid = (count != 0); deq_inst/deq_pc SHALL be combinational from the head entry; a pop occurs on deq_valid&&deq_ready.
REQ-011 Simultaneous push and pop SHALL leave count unchanged; pointers SHALL wrap modulo DEPTH.
REQ-012 On redirect: FIFO emptied (count 0), fetch_pc<=redirect_pc, resp_pc<=redirect_pc, drop_cnt<=drop_cnt+live_outstanding (minus 1 if a non-dropped response arrives that cycle), live_outstanding<=0; redirect SHALL take priority over same-cycle push and pop.
REQ-013 While drop_cnt != 0 each imem_rvalid SHALL decrement drop_cnt and be discarded; new requests MAY issue during drain.
REQ-014 imem_rvalid with drop_cnt==0 and live_outstanding==0 SHALL be discarded and set err_unexp.
REQ-015 imem_addr SHALL hold stable while imem_req is high and imem_ready is low.

Reset
REQ-016 While reset==0: imem_req=0, deq_valid=0, err_unexp=0, fetch_pc=resp_pc=RESET_PC, count=live_outstanding=drop_cnt=0, pointers 0.
REQ-017 First request SHALL be issued in the first cycle after reset deasserts.
REQ-018 Reset asserted mid-transfer SHALL abandon all outstanding requests; any response arriving after reset deassertion with nothing outstanding is handled per REQ-014.

Structure
REQ-019 Shared package riscv_fetch_pkg SHALL hold XLEN=32, INST_BYTES=4, and the fetch entry struct {pc, inst}.
REQ-020 Storage SHALL be a sub-module fetch_fifo (DEPTH x 64, push/pop/flush, count output); all counters and request logic stay in the top module.
REQ-021 Counter widths SHALL be $clog2(DEPTH)+1 bits.

Verification
REQ-022 Reset release, imem_ready=1, 1-cycle response latency, deq_ready=1 -> imem_addr 0,4,8,...; deq_pc 0,4,8 with matching deq_inst, one per cycle after fill.
REQ-023 deq_ready=0, DEPTH=4 -> exactly 4 requests accepted, imem_req low afterwards; deq_ready=1 for one cycle -> exactly one further request.
REQ-024 Two requests outstanding (addr 0x10, 0x14), redirect to 0x200 -> both responses discarded, first deq_pc=0x200, drop_cnt returns to 0.
REQ-025 imem_ready=0 for 5 cycles with imem_req high -> imem_addr constant; no count change.
REQ-026 Redirect in the same cycle as a push and a pop -> count=0, no stale entry appears, next deq_pc=redirect_pc.
REQ-027 Spurious imem_rvalid after reset with nothing outstanding -> err_unexp=1 and sticky, deq_valid stays 0.
